bit_serial_adder: RTL
=====================

Name: bit_serial_adder

Overview:
- Multi-cycle adder that adds two WIDTH-bit operands one bit per clock, LSB first.
- Uses a single 1-bit full-adder cell; the cell's carry-out is registered and fed back as the next bit's carry-in.
- Sits directly downstream of operand registers and directly upstream of result consumers.
- Trades latency for area versus a ripple-carry adder; uses a start/busy/done handshake.

Parameters:
- WIDTH, 8, operand and sum width in bits (legal range >= 1).

Ports:
- clk    input   1      single clock; all state changes on the rising edge.
- rst    input   1      synchronous, active-high reset.
- start  input   1      request a new addition; sampled only in IDLE.
- a      input   WIDTH  operand A; captured on the accepted start.
- b      input   WIDTH  operand B; captured on the accepted start.
- cin    input   1      initial carry-in; captured on the accepted start.
- busy   output  1      high while an operation is in RUN or DONE.
- done   output  1      one-cycle pulse; sum and cout are valid and final.
- sum    output  WIDTH  result register; holds the last completed result.
- cout   output  1      final carry-out; holds the last completed result.

Behaviour:
- Reset values (rst high at a rising edge): state=IDLE, busy=0, done=0, sum=0, cout=0, internal shift registers/counter/carry=0. Reset has priority over every other input.
- FSM state IDLE: busy=0.
  - start=1 loads a and b into shift registers sa and sb, sets carry_q to cin, clears the counter, and moves to RUN.
  - start=0 stays in IDLE.
- FSM state RUN: busy=1.
  - Each cycle, the cell computes s = sa[0]^sb[0]^carry_q and co = majority(sa[0], sb[0], carry_q).
  - s shifts into the MSB of the internal result shift register ss (ss shifts right).
  - sa and sb shift right; carry_q <= co; counter increments.
  - On the cycle where counter == WIDTH-1: sum <= the final ss value including this bit, cout <= co, go to DONE.
- FSM state DONE: busy=1, done=1 for exactly this cycle; always returns to IDLE next cycle.
- Timing:
  - Start accepted at edge T0.
  - RUN occupies the WIDTH cycles after T0.
  - done is high during cycle WIDTH+1 after T0.
  - busy is high for WIDTH+1 cycles.
  - Minimum issue interval is WIDTH+2 cycles.
- start while busy=1 (RUN or DONE) is ignored, not queued. a, b and cin may change freely after acceptance.
- sum and cout change only on the edge entering DONE (or on reset). Between operations they hold their value; during RUN they hold the previous result.
- Counter width is clog2(WIDTH)+1 so WIDTH values that are powers of two are handled. WIDTH=1 gives one RUN cycle.
- Arithmetic is unsigned modulo 2^WIDTH; the overflow appears only on cout. The result equals {cout, sum} = a + b + cin.
- Reset mid-RUN aborts the operation: no done pulse, sum and cout return to 0, state goes to IDLE.
- A start asserted in the same cycle as rst is dropped.

Decomposition:
- Shared package adder_pkg holds:
  - typedef state_t (IDLE, RUN, DONE);
  - function clog2 for the counter width.
- One natural sub-module: fa_cell (inputs x, y, ci; outputs s, co).
  - It is purely combinational and instantiated once.
  - The sequential carry register lives in bit_serial_adder.

Test Plan (WIDTH=8 unless noted):
- a=0x5A, b=0x3C, cin=0, start pulse -> done exactly 9 cycles after the accepted start, busy high for 9 cycles, sum=0x96, cout=0.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1. Then a=0x00, b=0x00, cin=0 -> sum=0x00, cout=0.
- Start 0x10+0x20, then assert start with a=0x77 during cycles 3 and 9 (the DONE cycle) -> only one done pulse, sum=0x30; the 0x77 operation never occurs.
- Start 0xAA+0x55, assert rst for 1 cycle at RUN cycle 4 -> busy=0, done never pulses, sum=0, cout=0. A following start of 0x01+0x02 gives sum=0x03.
- Back-to-back: start held high continuously with changing operands -> a new operation is accepted every 10 cycles, and each result matches the operands sampled at its own acceptance.
- WIDTH=1, a=1, b=1, cin=1 -> done 2 cycles after start, sum=1, cout=1. Follow with a random sweep of 1000 operations checked against a + b + cin.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared types and helpers for the bit-serial adder.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/bit_serial_adder_fa_cell.sv
// Single-bit combinational full adder used as the serial adder's arithmetic cell.
module fa_cell (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (x & ci) | (y & ci);

endmodule

// File: rtl/bit_serial_adder.sv
// Bit-serial adder: one full-adder cell, LSB first, carry registered between bits.
module bit_serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] ss_q, ss_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             fa_s, fa_co;
    logic [WIDTH-1:0] ss_shift;

    fa_cell u_fa (
        .x  (sa_q[0]),
        .y  (sb_q[0]),
        .ci (carry_q),
        .s  (fa_s),
        .co (fa_co)
    );

    // Shift-based form keeps WIDTH=1 legal (no reversed part-selects).
    assign ss_shift = (ss_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));

    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        ss_d    = ss_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    sa_d    = a;
                    sb_d    = b;
                    ss_d    = '0;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sa_d    = sa_q >> 1;
                sb_d    = sb_q >> 1;
                ss_d    = ss_shift;
                carry_d = fa_co;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
                    sum_d   = ss_shift;
                    cout_d  = fa_co;
                    state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            ss_q    <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            ss_q    <= ss_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule
